kaipokrandt_ctrl_seq: RTL and testbench
=======================================

# kaipokrandt_ctrl_seq

Top-level instruction sequencer for the microcontroller core. Fetches one instruction word per cycle-handshake from program memory and decodes the 4-bit opcode. Dispatches a one-cycle start pulse with a held one-hot decode line to the matching execution FSM (MOV, ADD, LOAD, STORE), then waits for that unit's done before advancing the PC. Handles NOP and HALT internally, and traps illegal opcodes and, optionally, hung units.

## Interface
Parameters:
- IW, 16, instruction width; opcode = ir[IW-1:IW-4], src_sel = ir[7:4], dst_sel = ir[3:0]
- AW, 8, PC / fetch address width
- TIMEOUT, 16, max WAIT cycles before watchdog fault (≥2)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high; clears all state
- run  in  1  level; allows leaving IDLE and continuing after each instruction
- clear  in  1  one-cycle pulse; exits HALT/FAULT to IDLE, PC unchanged
- fetch_req  out  1  memory read request
- fetch_addr  out  AW  equals pc
- fetch_ack  in  1  memory data valid
- fetch_data  in  IW  instruction word, sampled when fetch_ack=1 in FETCH
- start  out  1  one-cycle dispatch pulse
- dec_mov, dec_add, dec_ld, dec_st  out  1 each  one-hot unit select
- src_sel, dst_sel  out  4 each  register fields from ir
- done_mov, done_add, done_ld, done_st  in  1 each  unit completion pulses
- pc  out  AW  program counter
- ir  out  IW  instruction register
- busy  out  1  state not in {IDLE, HALT, FAULT}
- halted  out  1  state == HALT
- fault  out  1  state == FAULT
- fault_code  out  2  0 none, 1 illegal opcode, 2 watchdog timeout

## Operation
- States: IDLE, FETCH, DECODE, EXEC, WAIT, HALT, FAULT. Moore outputs decoded from state register.
- IDLE: run=1 → FETCH.
- FETCH: fetch_req=1 held until fetch_ack. On ack, ir ← fetch_data → DECODE. The request is never withdrawn before ack, even if run drops.
- DECODE, by opcode:
  - 0x0 NOP: pc ← pc+1, then FETCH if run else IDLE.
  - 0x1 MOV, 0x2 ADD, 0x3 LOAD, 0x4 STORE: → EXEC.
  - 0xF HALT: → HALT, pc not incremented.
  - Any other opcode: fault_code ← 1, → FAULT.
- EXEC: start=1 and matching dec_* =1 for one cycle → WAIT. Done inputs are ignored in EXEC.
- WAIT: matching dec_* held at 1. Done inputs from non-dispatched units are ignored. When the matching done =1: pc ← pc+1, then FETCH if run else IDLE.
- src_sel/dst_sel follow ir continuously and are valid from EXEC through WAIT.
- HALT/FAULT: hold until clear=1 → IDLE, fault_code ← 0. run is ignored.
- PC arithmetic is AW bits unsigned and wraps 2^AW−1 → 0.
- Reset, any state, mid-handshake included: state=IDLE, pc=0, ir=0, fault_code=0, and every output 0 except fetch_addr=0.

## Timing
- Minimum instruction latency: FETCH(1, ack same cycle) + DECODE(1) + EXEC(1) + WAIT(≥1). A MOV unit answering done two cycles after start takes 5 cycles ack-to-next-fetch_req.
- NOP costs 2 cycles with a zero-wait ack.
- In WAIT, a done arriving on the same cycle the watchdog expires takes priority; the instruction completes normally.
- start is never asserted in any state other than EXEC. dec_* are all zero outside EXEC/WAIT.
- clear and reset arriving in the same cycle: reset wins.

## Configuration
- CTRL_WATCHDOG_EN defined: a cycle counter clears on entry to WAIT and increments each WAIT cycle. If it reaches TIMEOUT without a matching done: fault_code ← 2, → FAULT, dec_* drop.
- Undefined: no counter, WAIT is unbounded, and fault_code 2 is never produced.

## Test plan
- Reset then run=1, memory returns 0x1_0_2_3 (MOV) with 0-wait ack, done_mov 2 cycles after start → start one pulse, dec_mov high 3 cycles, src_sel=2, dst_sel=3, pc 0→1, next fetch_req 5 cycles after the first ack.
- Ack delayed 4 cycles and run dropped during FETCH → fetch_req held all 4 cycles; instruction completes; then IDLE with busy=0.
- Opcode 0x7 → fault=1, fault_code=1, pc unchanged. clear pulse → IDLE, fault_code=0.
- Dispatch ADD, pulse done_mov, never done_add, TIMEOUT=16 → done_mov ignored. With CTRL_WATCHDOG_EN: FAULT, fault_code=2 after 16 WAIT cycles. Without the macro: stays in WAIT for 100 cycles.
- pc preset to 0xFF via a NOP stream, one more NOP → pc=0x00. HALT (0xF000) → halted=1, pc held, run ignored.
- Reset asserted in WAIT → next cycle IDLE, pc=0, all outputs 0.

Source files
------------

// File: rtl/kaipokrandt_ctrl_seq.sv
// Instruction sequencer: fetch, decode and dispatch to the MOV/ADD/LOAD/STORE units, with traps for illegal opcodes.
// Defining CTRL_WATCHDOG_EN adds a WAIT-state timeout that faults a hung unit with fault_code 2.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | parked, waiting for run
// S_FETCH  | fetch_req held until fetch_ack, then latch ir
// S_DECODE | classify opcode: NOP/HALT handled here, units to EXEC, else FAULT
// S_EXEC   | one-cycle start pulse to the selected unit
// S_WAIT   | hold dec_* until the selected unit's done
// S_HALT   | halted until clear
// S_FAULT  | trapped until clear, fault_code reports the cause
module kaipokrandt_ctrl_seq #(
    parameter int IW      = 16,
    parameter int AW      = 8,
    parameter int TIMEOUT = 16
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          run_i,
    input  logic          clear_i,
    output logic          fetch_req_o,
    output logic [AW-1:0] fetch_addr_o,
    input  logic          fetch_ack_i,
    input  logic [IW-1:0] fetch_data_i,
    output logic          start_o,
    output logic          dec_mov_o,
    output logic          dec_add_o,
    output logic          dec_ld_o,
    output logic          dec_st_o,
    output logic [3:0]    src_sel_o,
    output logic [3:0]    dst_sel_o,
    input  logic          done_mov_i,
    input  logic          done_add_i,
    input  logic          done_ld_i,
    input  logic          done_st_i,
    output logic [AW-1:0] pc_o,
    output logic [IW-1:0] ir_o,
    output logic          busy_o,
    output logic          halted_o,
    output logic          fault_o,
    output logic [1:0]    fault_code_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WAIT, S_HALT, S_FAULT
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_MOV  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_LD   = 4'h3;
    localparam logic [3:0] OP_ST   = 4'h4;
    localparam logic [3:0] OP_HALT = 4'hF;

    if (TIMEOUT < 2) begin : g_timeout_check
        $error("TIMEOUT must be at least 2");
    end

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [IW-1:0] ir_q, ir_d;
    logic [1:0]    fault_code_q, fault_code_d;
    logic [3:0]    dec_q, dec_d;
    logic          fetch_req_q, start_q, busy_q, halted_q, fault_q;
    logic          unit_done;

    // One-hot unit select, bit order {st, ld, add, mov}
    function automatic logic [3:0] unit_sel(input logic [3:0] op);
        case (op)
            OP_MOV:  return 4'b0001;
            OP_ADD:  return 4'b0010;
            OP_LD:   return 4'b0100;
            OP_ST:   return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    assign unit_done = |(dec_q & {done_st_i, done_ld_i, done_add_i, done_mov_i});

`ifdef CTRL_WATCHDOG_EN
    localparam int WDW = $clog2(TIMEOUT);
    logic [WDW-1:0] wd_q, wd_d;

    // Down-counter loaded on WAIT entry; terminal count 0 marks the last allowed WAIT cycle.
    always_comb begin
        wd_d = wd_q;
        if (state_q == S_EXEC) begin
            wd_d = WDW'(TIMEOUT - 1);
        end else if (state_q == S_WAIT && wd_q != '0) begin
            wd_d = wd_q - WDW'(1);
        end
    end
`endif

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        fault_code_d = fault_code_q;
        case (state_q)
            S_IDLE: begin
                if (run_i) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (fetch_ack_i) begin
                    ir_d    = fetch_data_i;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (ir_q[IW-1 -: 4])
                    OP_NOP: begin
                        pc_d    = pc_q + AW'(1);
                        state_d = run_i ? S_FETCH : S_IDLE;
                    end
                    OP_MOV, OP_ADD, OP_LD, OP_ST: state_d = S_EXEC;
                    OP_HALT: state_d = S_HALT;
                    default: begin
                        fault_code_d = 2'd1;
                        state_d      = S_FAULT;
                    end
                endcase
            end
            S_EXEC: state_d = S_WAIT;
            S_WAIT: begin
                // A done on the expiry cycle still completes the instruction.
                if (unit_done) begin
                    pc_d    = pc_q + AW'(1);
                    state_d = run_i ? S_FETCH : S_IDLE;
                end
`ifdef CTRL_WATCHDOG_EN
                else if (wd_q == '0) begin
                    fault_code_d = 2'd2;
                    state_d      = S_FAULT;
                end
`endif
            end
            S_HALT, S_FAULT: begin
                if (clear_i) begin
                    state_d      = S_IDLE;
                    fault_code_d = 2'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        dec_d = (state_d == S_EXEC || state_d == S_WAIT) ? unit_sel(ir_d[IW-1 -: 4]) : 4'b0000;
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            pc_q         <= '0;
            ir_q         <= '0;
            fault_code_q <= 2'd0;
            dec_q        <= 4'b0000;
            fetch_req_q  <= 1'b0;
            start_q      <= 1'b0;
            busy_q       <= 1'b0;
            halted_q     <= 1'b0;
            fault_q      <= 1'b0;
`ifdef CTRL_WATCHDOG_EN
            wd_q         <= '0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            fault_code_q <= fault_code_d;
            dec_q        <= dec_d;
            fetch_req_q  <= (state_d == S_FETCH);
            start_q      <= (state_d == S_EXEC);
            busy_q       <= !(state_d inside {S_IDLE, S_HALT, S_FAULT});
            halted_q     <= (state_d == S_HALT);
            fault_q      <= (state_d == S_FAULT);
`ifdef CTRL_WATCHDOG_EN
            wd_q         <= wd_d;
`endif
        end
    end

    assign fetch_req_o  = fetch_req_q;
    assign fetch_addr_o = pc_q;
    assign start_o      = start_q;
    assign dec_mov_o    = dec_q[0];
    assign dec_add_o    = dec_q[1];
    assign dec_ld_o     = dec_q[2];
    assign dec_st_o     = dec_q[3];
    assign src_sel_o    = ir_q[7:4];
    assign dst_sel_o    = ir_q[3:0];
    assign pc_o         = pc_q;
    assign ir_o         = ir_q;
    assign busy_o       = busy_q;
    assign halted_o     = halted_q;
    assign fault_o      = fault_q;
    assign fault_code_o = fault_code_q;

endmodule

// File: tb/tb_kaipokrandt_ctrl_seq.sv
// Bench for kaipokrandt_ctrl_seq: dispatches are scoreboarded, control-path behaviour is checked directly.
module tb_kaipokrandt_ctrl_seq;

    logic        clk_i = 1'b0;
    logic        reset_i, run_i, clear_i;
    logic        fetch_req_o, fetch_ack_i;
    logic [7:0]  fetch_addr_o, pc_o;
    logic [15:0] fetch_data_i, ir_o;
    logic        start_o, dec_mov_o, dec_add_o, dec_ld_o, dec_st_o;
    logic [3:0]  src_sel_o, dst_sel_o;
    logic        done_mov_i, done_add_i, done_ld_i, done_st_i;
    logic        busy_o, halted_o, fault_o;
    logic [1:0]  fault_code_o;

    always #5 clk_i = ~clk_i;

    kaipokrandt_ctrl_seq dut (
        .clk_i(clk_i), .reset_i(reset_i), .run_i(run_i), .clear_i(clear_i),
        .fetch_req_o(fetch_req_o), .fetch_addr_o(fetch_addr_o),
        .fetch_ack_i(fetch_ack_i), .fetch_data_i(fetch_data_i),
        .start_o(start_o), .dec_mov_o(dec_mov_o), .dec_add_o(dec_add_o),
        .dec_ld_o(dec_ld_o), .dec_st_o(dec_st_o),
        .src_sel_o(src_sel_o), .dst_sel_o(dst_sel_o),
        .done_mov_i(done_mov_i), .done_add_i(done_add_i),
        .done_ld_i(done_ld_i), .done_st_i(done_st_i),
        .pc_o(pc_o), .ir_o(ir_o), .busy_o(busy_o), .halted_o(halted_o),
        .fault_o(fault_o), .fault_code_o(fault_code_o)
    );

    typedef struct packed {
        logic [3:0] dec;
        logic [3:0] src;
        logic [3:0] dst;
    } exp_t;

    exp_t       sb_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] unit_of(input logic [15:0] w);
        case (w[15:12])
            4'h1:    return 4'b0001;
            4'h2:    return 4'b0010;
            4'h3:    return 4'b0100;
            4'h4:    return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [3:0] dec_vec();
        return {dec_st_o, dec_ld_o, dec_add_o, dec_mov_o};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Every start pulse must match the oldest dispatched instruction.
    always @(negedge clk_i) begin
        exp_t e;
        if (start_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_start", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("sb_dec", {28'd0, dec_vec()}, {28'd0, e.dec});
                chk("sb_src", {28'd0, src_sel_o}, {28'd0, e.src});
                chk("sb_dst", {28'd0, dst_sel_o}, {28'd0, e.dst});
            end
        end
    end

    task automatic fetch(input logic [15:0] w, input int dly);
        exp_t e;
        int   guard = 0;
        while (fetch_req_o !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        chk("fetch_req_seen", {31'd0, fetch_req_o}, 32'd1);
        chk("fetch_addr", {24'd0, fetch_addr_o}, {24'd0, exp_pc});
        for (int i = 0; i < dly; i++) begin
            tick();
            chk("fetch_req_held", {31'd0, fetch_req_o}, 32'd1);
        end
        fetch_ack_i  = 1'b1;
        fetch_data_i = w;
        if (unit_of(w) != 4'b0000) begin
            e.dec = unit_of(w);
            e.src = w[7:4];
            e.dst = w[3:0];
            sb_q.push_back(e);
        end
        tick();
        fetch_ack_i  = 1'b0;
        fetch_data_i = '0;
    endtask

    // Fetch and run one unit instruction; done is pulsed done_dly cycles after start.
    task automatic exec_unit(input logic [15:0] w, input int ack_dly, input int done_dly);
        logic [3:0] u;
        int         ndec;
        u = unit_of(w);
        fetch(w, ack_dly);
        chk("decode_no_start", {31'd0, start_o}, 32'd0);
        tick();
        chk("exec_start", {31'd0, start_o}, 32'd1);
        ndec = (dec_vec() == u) ? 1 : 0;
        for (int i = 0; i < done_dly; i++) begin
            tick();
            chk("wait_no_start", {31'd0, start_o}, 32'd0);
            if (dec_vec() == u) ndec++;
        end
        {done_st_i, done_ld_i, done_add_i, done_mov_i} = u;
        tick();
        {done_st_i, done_ld_i, done_add_i, done_mov_i} = 4'b0000;
        chk("dec_cycles", ndec, done_dly + 1);
        chk("dec_drop", {28'd0, dec_vec()}, 32'd0);
        exp_pc = exp_pc + 8'd1;
        chk("pc_after_exec", {24'd0, pc_o}, {24'd0, exp_pc});
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
        chk({tag, "_req"}, {31'd0, fetch_req_o}, 32'd0);
        chk({tag, "_start"}, {31'd0, start_o}, 32'd0);
        chk({tag, "_dec"}, {28'd0, dec_vec()}, 32'd0);
        chk({tag, "_pc"}, {24'd0, pc_o}, 32'd0);
        chk({tag, "_addr"}, {24'd0, fetch_addr_o}, 32'd0);
        chk({tag, "_ir"}, {16'd0, ir_o}, 32'd0);
        chk({tag, "_sel"}, {24'd0, src_sel_o, dst_sel_o}, 32'd0);
        chk({tag, "_halt"}, {31'd0, halted_o}, 32'd0);
        chk({tag, "_fault"}, {29'd0, fault_o, fault_code_o}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset_i = 1'b1; run_i = 1'b0; clear_i = 1'b0;
        fetch_ack_i = 1'b0; fetch_data_i = '0;
        {done_st_i, done_ld_i, done_add_i, done_mov_i} = 4'b0000;
        exp_pc = 8'd0;
        tick();
        tick();
        chk_all_zero("rst");

        // MOV r2->r3, zero-wait ack, done two cycles after start
        reset_i = 1'b0;
        run_i   = 1'b1;
        tick();
        exec_unit(16'h1023, 0, 2);
        chk("t1_next_req", {31'd0, fetch_req_o}, 32'd1);
        chk("t1_ir", {16'd0, ir_o}, 32'h1023);

        // Slow ack with run dropped mid-fetch
        run_i = 1'b0;
        exec_unit(16'h3456, 4, 1);
        chk("t2_busy", {31'd0, busy_o}, 32'd0);
        chk("t2_req", {31'd0, fetch_req_o}, 32'd0);
        tick();
        chk("t2_idle", {31'd0, busy_o}, 32'd0);

        // Illegal opcode trap and clear
        run_i = 1'b1;
        tick();
        fetch(16'h7000, 0);
        tick();
        chk("t3_fault", {31'd0, fault_o}, 32'd1);
        chk("t3_code", {30'd0, fault_code_o}, 32'd1);
        chk("t3_pc", {24'd0, pc_o}, {24'd0, exp_pc});
        chk("t3_busy", {31'd0, busy_o}, 32'd0);
        tick();
        chk("t3_fault_hold", {31'd0, fault_o}, 32'd1);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("t3_clr_fault", {29'd0, fault_o, fault_code_o}, 32'd0);
        chk("t3_clr_busy", {31'd0, busy_o}, 32'd0);
        chk("t3_clr_pc", {24'd0, pc_o}, {24'd0, exp_pc});

        // ADD with a stray done_mov and no done_add
        tick();
        fetch(16'h2045, 0);
        tick();
        tick();
        done_mov_i = 1'b1;
        tick();
        done_mov_i = 1'b0;
        chk("t4_dec_add", {31'd0, dec_add_o}, 32'd1);
        chk("t4_busy", {31'd0, busy_o}, 32'd1);
`ifdef CTRL_WATCHDOG_EN
        repeat (14) tick();
        chk("t4_wd_not_yet", {31'd0, fault_o}, 32'd0);
        chk("t4_wd_dec_hold", {31'd0, dec_add_o}, 32'd1);
        tick();
        chk("t4_wd_fault", {31'd0, fault_o}, 32'd1);
        chk("t4_wd_code", {30'd0, fault_code_o}, 32'd2);
        chk("t4_wd_dec", {28'd0, dec_vec()}, 32'd0);
        chk("t4_wd_pc", {24'd0, pc_o}, {24'd0, exp_pc});
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        tick();
        fetch(16'h2067, 0);
        tick();
        tick();
        repeat (15) tick();
        done_add_i = 1'b1;
        tick();
        done_add_i = 1'b0;
        exp_pc = exp_pc + 8'd1;
        chk("t4_tie_fault", {29'd0, fault_o, fault_code_o}, 32'd0);
        chk("t4_tie_pc", {24'd0, pc_o}, {24'd0, exp_pc});
        chk("t4_tie_req", {31'd0, fetch_req_o}, 32'd1);
`else
        repeat (100) tick();
        chk("t4_hang_busy", {31'd0, busy_o}, 32'd1);
        chk("t4_hang_dec", {31'd0, dec_add_o}, 32'd1);
        chk("t4_hang_fault", {29'd0, fault_o, fault_code_o}, 32'd0);
        done_add_i = 1'b1;
        tick();
        done_add_i = 1'b0;
        exp_pc = exp_pc + 8'd1;
        chk("t4_done_pc", {24'd0, pc_o}, {24'd0, exp_pc});
        chk("t4_done_req", {31'd0, fetch_req_o}, 32'd1);
`endif

        // NOP stream up to 0xFF, then wrap
        while (exp_pc != 8'hFF) begin
            fetch(16'h0000, 0);
            tick();
            exp_pc = exp_pc + 8'd1;
        end
        chk("t5_pc_ff", {24'd0, pc_o}, 32'hFF);
        fetch(16'h0000, 0);
        chk("t5_nop_decode", {31'd0, fetch_req_o}, 32'd0);
        tick();
        exp_pc = 8'd0;
        chk("t5_pc_wrap", {24'd0, pc_o}, 32'd0);
        chk("t5_nop_2cyc", {31'd0, fetch_req_o}, 32'd1);

        // HALT holds pc and ignores run
        fetch(16'hF000, 0);
        tick();
        chk("t5_halted", {31'd0, halted_o}, 32'd1);
        chk("t5_halt_busy", {31'd0, busy_o}, 32'd0);
        repeat (3) tick();
        chk("t5_halt_hold", {31'd0, halted_o}, 32'd1);
        chk("t5_halt_req", {31'd0, fetch_req_o}, 32'd0);
        chk("t5_halt_pc", {24'd0, pc_o}, 32'd0);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("t5_clr_halt", {31'd0, halted_o}, 32'd0);

        // Reset while a unit is in WAIT
        tick();
        fetch(16'h0000, 0);
        tick();
        exp_pc = 8'd1;
        chk("t6_pc1", {24'd0, pc_o}, 32'd1);
        fetch(16'h1023, 0);
        tick();
        tick();
        chk("t6_in_wait", {31'd0, dec_mov_o}, 32'd1);
        reset_i = 1'b1;
        tick();
        chk_all_zero("t6_rst");
        reset_i = 1'b0;
        exp_pc  = 8'd0;

        // Reset and clear together from FAULT: reset wins, pc cleared
        tick();
        fetch(16'h0000, 0);
        tick();
        exp_pc = 8'd1;
        fetch(16'h7000, 0);
        tick();
        chk("t7_fault", {31'd0, fault_o}, 32'd1);
        chk("t7_pc", {24'd0, pc_o}, 32'd1);
        clear_i = 1'b1;
        reset_i = 1'b1;
        tick();
        clear_i = 1'b0;
        reset_i = 1'b0;
        chk("t7_pc_rst", {24'd0, pc_o}, 32'd0);
        chk("t7_fault_rst", {29'd0, fault_o, fault_code_o}, 32'd0);

        chk("sb_empty", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
